booth_seq_mult: RTL and testbench
=================================

Name: booth_seq_mult

Overview:
Parametrised sequential radix-2 Booth signed multiplier. It generalises the team's fixed 4-bit shift-right Q register into a complete multiplier datapath: accumulator A, multiplier register Q with appended Q-1 bit, multiplicand register M, iteration counter and a control FSM. The block sits between the operand source and the result consumer, with a start/done handshake on each side.

Parameters:
- WIDTH, default 4: operand width in bits (two's complement). Legal range is 2..32.
- CNT_W, default $clog2(WIDTH+2): iteration counter width. Derived; not overridden.

Ports:
- i_clk, input, 1: clock. All state updates on the rising edge.
- i_rst_n, input, 1: asynchronous, active-low reset.
- i_start, input, 1: request to start; sampled only in IDLE.
- i_data_m, input, WIDTH: multiplicand; captured when i_start is accepted.
- i_data_q, input, WIDTH: multiplier; captured when i_start is accepted.
- o_busy, output, 1: high from the accept cycle until o_done is asserted.
- o_done, output, 1: single-cycle pulse; o_product is valid in that cycle.
- o_product, output, 2*WIDTH: signed product. Held until the next accepted start.

Behaviour:
- Reset: while i_rst_n is low, all registers clear asynchronously.
  - o_busy=0, o_done=0, o_product=0, FSM=IDLE.
  - Reset asserted mid-operation aborts the operation; no o_done is produced.
- Internal widths:
  - A is WIDTH+1 bits, so that A-M with M = most-negative cannot overflow.
  - Q register is WIDTH+1 bits, laid out {multiplier, q_m1}.
  - M is WIDTH+1 bits, sign-extended.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE:
  - If i_start=1: latch operands, A=0, Q={i_data_q,1'b0}, M=sext(i_data_m), counter=0. Go to ITER. o_busy rises on the next edge.
  - If i_start=0: hold state.
- ITER, one Booth step per cycle:
  - Inspect Q[1:0]. 01 gives A=A+M; 10 gives A=A-M; 00 and 11 leave A unchanged.
  - Then arithmetic right shift of {A,Q}: A's MSB is replicated, A[0] enters Q's MSB, and Q[0] is discarded.
  - Increment the counter. After WIDTH steps, go to DONE.
- DONE:
  - o_product = {A[WIDTH-1:0], Q[WIDTH:1]}, registered.
  - o_done=1 for exactly one cycle, o_busy=0.
  - Return to IDLE.
- LOAD: reserved encoding. If entered, it goes to IDLE on the next cycle with no output change.
- Latency:
  - Accept edge to o_done = WIDTH+1 cycles (4-bit: 5 cycles).
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
- Handshake edges:
  - i_start while busy is ignored; operands are not re-sampled.
  - i_start in the DONE cycle is ignored. It is accepted in the following IDLE cycle.
  - i_start held high continuously starts a new operation every WIDTH+2 cycles.
- Corner cases that must be exact:
  - (-2^(W-1)) * (-2^(W-1)) = +2^(2W-2).
  - Any zero operand gives 0.
  - Mixed-sign products are correctly sign-extended to 2*WIDTH bits.

Optional Feature:
- Macro: BOOTH_UNSIGNED_MODE_EN.
- When defined:
  - Adds port i_signed (input, 1), captured at accept.
  - With i_signed=0, both operands are zero-extended to WIDTH+1 bits and the loop runs WIDTH+1 steps. Latency becomes WIDTH+2 cycles.
  - o_product is the unsigned 2*WIDTH-bit product.
  - With i_signed=1, behaviour is identical to the signed path.
- When undefined: the port is absent and the block is always signed.

Decomposition:
- Package mult_pkg holds:
  - FSM state encoding constants (IDLE=2'd0, LOAD=2'd1, ITER=2'd2, DONE=2'd3).
  - Booth op codes (NOP, ADD, SUB).
  - The default WIDTH.
- One sub-module, booth_step (combinational):
  - Inputs: A, Q, M.
  - Outputs: next A and next Q after add/sub and arithmetic shift.
  - booth_seq_mult instantiates it once and registers its outputs.

Test Plan (WIDTH=4):
- Start with m=3, q=-5 (4'hB). Expected: o_done exactly 5 cycles after accept; o_product=8'hF1 (-15).
- m=-8, q=-8. Expected: o_product=8'h40 (+64).
- m=7, q=7. Expected: 8'h31. Then m=-8, q=7: expected 8'hC8 (-56).
- Start at m=5, q=2. Pulse i_start with m=1, q=1 at cycle 2 of the operation. Expected: ignored; result 8'h0A. Next start m=0, q=-8 gives 8'h00.
- Start m=6, q=-3, then drop i_rst_n at cycle 3. Expected: o_busy=0, o_product=0 and no o_done. A fresh start afterwards yields correct results.
- With BOOTH_UNSIGNED_MODE_EN: i_signed=0, m=4'hF, q=4'hF. Expected: 8'hE1 (225) with 6-cycle latency. i_signed=1 with the same operands gives 8'h01.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_pkg;

   localparam int unsigned DefaultWidth = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StIter = 2'd2,
      StDone = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      OpNop = 2'd0,
      OpAdd = 2'd1,
      OpSub = 2'd2
   } booth_op_e;

   // Radix-2 Booth recoding of {q0, q_m1}.
   function automatic booth_op_e booth_decode(input logic [1:0] qbits);
      booth_op_e op;
      case (qbits)
         2'b01:   op = OpAdd;
         2'b10:   op = OpSub;
         default: op = OpNop;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: add/sub M into A, then arithmetic
// right shift of {A, Q}.
module booth_step
   import mult_pkg::*;
#(
   parameter int unsigned N = DefaultWidth
) (
   input  logic [N:0] a_i,
   input  logic [N:0] q_i,
   input  logic [N:0] m_i,
   output logic [N:0] a_o,
   output logic [N:0] q_o
);

   logic [N:0] sum;

   // Recode, accumulate, then shift A's LSB into Q's MSB.
   always_comb begin
      sum = a_i;
      case (booth_decode(q_i[1:0]))
         OpAdd:   sum = a_i + m_i;
         OpSub:   sum = a_i - m_i;
         default: sum = a_i;
      endcase
      a_o = {sum[N], sum[N:1]};
      q_o = {sum[0], q_i[N:1]};
   end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth signed multiplier with start/done handshake.
// Optional macro BOOTH_UNSIGNED_MODE_EN adds i_signed for unsigned products.
module booth_seq_mult
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned CNT_W = $clog2(WIDTH + 2)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [WIDTH-1:0]     i_data_m,
   input  logic [WIDTH-1:0]     i_data_q,
`ifdef BOOTH_UNSIGNED_MODE_EN
   input  logic                 i_signed,
`endif
   output logic                 o_busy,
   output logic                 o_done,
   output logic [2*WIDTH-1:0]   o_product
);

`ifdef BOOTH_UNSIGNED_MODE_EN
   // One extra operand bit lets unsigned operands be zero-extended.
   localparam int unsigned N = WIDTH + 1;
   logic uns_q, uns_d;
`else
   localparam int unsigned N = WIDTH;
`endif

   state_e             state_q, state_d;
   logic [N:0]         a_q, a_d;
   logic [N:0]         q_q, q_d;
   logic [N:0]         m_q, m_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;

   logic [N:0]         a_nxt, q_nxt;
   logic [N:0]         m_load, q_load;
   logic [CNT_W-1:0]   last_cnt;
   logic [2*WIDTH-1:0] prod_nxt;
   logic               unused_step_bits;

   booth_step #(
      .N (N)
   ) u_step (
      .a_i (a_q),
      .q_i (q_q),
      .m_i (m_q),
      .a_o (a_nxt),
      .q_o (q_nxt)
   );

`ifdef BOOTH_UNSIGNED_MODE_EN
   assign m_load   = {{(N + 1 - WIDTH){i_signed & i_data_m[WIDTH-1]}}, i_data_m};
   assign q_load   = {i_signed & i_data_q[WIDTH-1], i_data_q, 1'b0};
   assign last_cnt = uns_q ? CNT_W'(WIDTH) : CNT_W'(WIDTH - 1);
   // Signed ops stop one step early, so the product sits one bit higher in {A, Q}.
   assign prod_nxt = uns_q ? {a_nxt[WIDTH-2:0], q_nxt[N:1]}
                           : {a_nxt[WIDTH-1:0], q_nxt[N:2]};
`else
   assign m_load   = {{(N + 1 - WIDTH){i_data_m[WIDTH-1]}}, i_data_m};
   assign q_load   = {i_data_q, 1'b0};
   assign last_cnt = CNT_W'(WIDTH - 1);
   assign prod_nxt = {a_nxt[WIDTH-1:0], q_nxt[N:1]};
`endif

   // Guard bits of the step outputs never reach the product.
   assign unused_step_bits = ^{a_nxt, q_nxt};

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      prod_d  = prod_q;
`ifdef BOOTH_UNSIGNED_MODE_EN
      uns_d   = uns_q;
`endif
      case (state_q)
         StIdle: begin
            if (i_start) begin
               a_d     = '0;
               q_d     = q_load;
               m_d     = m_load;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = StIter;
`ifdef BOOTH_UNSIGNED_MODE_EN
               uns_d   = ~i_signed;
`endif
            end
         end
         StIter: begin
            a_d   = a_nxt;
            q_d   = q_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == last_cnt) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               prod_d  = prod_nxt;
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         StLoad:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prod_q  <= '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
         uns_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         prod_q  <= prod_d;
`ifdef BOOTH_UNSIGNED_MODE_EN
         uns_q   <= uns_d;
`endif
      end
   end

   assign o_busy    = busy_q;
   assign o_done    = done_q;
   assign o_product = prod_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult at WIDTH=4.
module tb_booth_seq_mult;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] dm;
   logic [3:0] dq;
   logic       busy;
   logic       done;
   logic [7:0] product;
`ifdef BOOTH_UNSIGNED_MODE_EN
   logic       sgn;
`endif

   int checks;
   int errors;
   int lat;
   logic seen;

   booth_seq_mult #(
      .WIDTH (4)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_start   (start),
      .i_data_m  (dm),
      .i_data_q  (dq),
`ifdef BOOTH_UNSIGNED_MODE_EN
      .i_signed  (sgn),
`endif
      .o_busy    (busy),
      .o_done    (done),
      .o_product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launch one operation; lat counts edges from the accept edge (inclusive)
   // to the edge after which o_done is seen. glitch>0 pulses a stray start.
   task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp_p,
                         input int exp_lat, input int glitch, input string tag);
      @(negedge clk);
      dm    = m;
      dq    = q;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         if (lat == glitch) begin
            start = 1'b1;
            dm    = 4'h1;
            dq    = 4'h1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         lat++;
         seen = done;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_product"}, 32'(product), 32'(exp_p));
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_done_single"}, 32'(done), 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      dm     = '0;
      dq     = '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
      sgn    = 1'b1;
`endif

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Signed products and corner cases
      run_op(4'h3, 4'hB, 8'hF1, 5, 0, "m3_qm5");
      run_op(4'h8, 4'h8, 8'h40, 5, 0, "mneg8_qneg8");
      run_op(4'h7, 4'h7, 8'h31, 5, 0, "m7_q7");
      run_op(4'h8, 4'h7, 8'hC8, 5, 0, "mneg8_q7");
      run_op(4'h1, 4'h8, 8'hF8, 5, 0, "m1_qneg8");
      run_op(4'hF, 4'hF, 8'h01, 5, 0, "mneg1_qneg1");

      // Stray start during operation is ignored
      run_op(4'h5, 4'h2, 8'h0A, 5, 2, "m5_q2_ignored_start");
      run_op(4'h0, 4'h8, 8'h00, 5, 0, "m0_qneg8");
      run_op(4'h7, 4'hF, 8'hF9, 5, 0, "m7_qneg1");

      // Held start: one operation every WIDTH+2 cycles, DONE-cycle start ignored
      @(negedge clk);
      dm    = 4'h2;
      dq    = 4'h3;
      start = 1'b1;
      lat   = 0;
      seen  = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         seen = done;
      end
      check("held_first_latency", 32'(lat), 32'd5);
      check("held_first_product", 32'(product), 32'h06);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         seen = done;
      end
      start = 1'b0;
      check("held_period", 32'(lat), 32'd6);
      check("held_second_product", 32'(product), 32'h06);
      repeat (2) @(posedge clk);
      #1;
      check("held_release_idle", 32'(busy), 32'd0);

      // Reset mid-operation aborts without a done pulse
      @(negedge clk);
      dm    = 4'h6;
      dq    = 4'hD;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("abort_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_product", 32'(product), 32'd0);
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         seen = seen | done;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
         seen = seen | done;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      run_op(4'h6, 4'hD, 8'hEE, 5, 0, "m6_qm3_after_reset");

`ifdef BOOTH_UNSIGNED_MODE_EN
      // Unsigned mode runs one extra step
      sgn = 1'b0;
      run_op(4'hF, 4'hF, 8'hE1, 6, 0, "uns_mF_qF");
      sgn = 1'b1;
      run_op(4'hF, 4'hF, 8'h01, 5, 0, "sgn_mF_qF");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
